// File: rtl/traffic_generator_gmii_engine.sv
// GMII frame replay engine: plays a template RAM out as bursts of frames with
// programmable interframe/interburst gaps and counts completed frames.
module traffic_generator_gmii_engine #(
    parameter int C_FRAME_BUF_ADDRESS_WIDTH = 9
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic [31:0]                          control_reg,
    input  logic [31:0]                          interframe_gap_reg,
    input  logic [31:0]                          interburst_gap_reg,
    input  logic [31:0]                          frames_per_burst_reg,
    input  logic [63:0]                          total_frames_reg,
    input  logic [15:0]                          frame_size_reg,
    input  logic [31:0]                          frame_buf_data,
    input  logic [C_FRAME_BUF_ADDRESS_WIDTH-1:0] frame_buf_address,
    input  logic                                 frame_buf_wr,
    output logic [7:0]                           gmii_txd,
    output logic                                 gmii_tx_en,
    output logic                                 gmii_tx_er,
    output logic [63:0]                          pkts_reg,
    output logic                                 busy
);
    localparam int W = C_FRAME_BUF_ADDRESS_WIDTH;
    localparam logic [16:0] MAX_BYTES = 17'(4 * (2 ** W));

    typedef enum logic [2:0] {IDLE, PREFETCH, FRAME, GAP, DONE} state_t;

    state_t        state_q;
    logic          run_q;
    logic          start_q;
    logic          stop_pending_q;
    logic [16:0]   size_q;
    logic [31:0]   ifg_q;
    logic [31:0]   ibg_q;
    logic [31:0]   fpb_q;
    logic [63:0]   total_q;
    logic [63:0]   pkts_q;
    logic [31:0]   burst_cnt_q;
    logic [31:0]   gap_cnt_q;
    logic [16:0]   byte_cnt_q;
    logic [7:0]    txd_q;
    logic          tx_en_q;

    logic [31:0]   mem [0:(2**W)-1];
    logic [31:0]   rdata_q;
    logic          rd_en;
    logic [W-1:0]  rd_addr;

    logic          run;
    logic [16:0]   size_clip;
    logic          frame_last;
    logic [31:0]   burst_next;
    logic          burst_end;
    logic [31:0]   gap_sel;
    logic [31:0]   gap_load;
    logic          total_hit;
    logic          gap_restart;
    logic [7:0]    lane_byte;
    logic          unused_ctrl_bits;

    assign run              = control_reg[0];
    assign unused_ctrl_bits = ^control_reg[31:1];

    assign size_clip   = ({1'b0, frame_size_reg} > MAX_BYTES) ? MAX_BYTES : {1'b0, frame_size_reg};
    assign frame_last  = (byte_cnt_q == size_q - 17'd1);
    assign burst_next  = burst_cnt_q + 32'd1;
    assign burst_end   = (fpb_q != 32'd0) && (burst_next == fpb_q);
    assign gap_sel     = burst_end ? ibg_q : ifg_q;
    assign gap_load    = (gap_sel == 32'd0) ? 32'd0 : gap_sel - 32'd1;
    assign total_hit   = (total_q != 64'd0) && (pkts_q == total_q);
    // The last gap clock doubles as the prefetch of the next frame, so the
    // idle time on the wire equals the programmed gap exactly.
    assign gap_restart = (gap_cnt_q == 32'd0) && run && !stop_pending_q && !total_hit;

    always_comb begin
        rd_en   = 1'b0;
        rd_addr = '0;
        case (state_q)
            PREFETCH: rd_en = 1'b1;
            GAP:      rd_en = gap_restart;
            FRAME: begin
                rd_en   = (byte_cnt_q[1:0] == 2'd3);
                rd_addr = byte_cnt_q[W+1:2] + W'(1);
            end
            default: rd_en = 1'b0;
        endcase
    end

    always_comb begin
        case (byte_cnt_q[1:0])
            2'd0:    lane_byte = rdata_q[31:24];
            2'd1:    lane_byte = rdata_q[23:16];
            2'd2:    lane_byte = rdata_q[15:8];
            default: lane_byte = rdata_q[7:0];
        endcase
    end

    // Template RAM is never reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (frame_buf_wr) begin
            mem[frame_buf_address] <= frame_buf_data;
        end
        if (rd_en) begin
            rdata_q <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= IDLE;
            run_q          <= 1'b0;
            start_q        <= 1'b0;
            stop_pending_q <= 1'b0;
            size_q         <= '0;
            ifg_q          <= '0;
            ibg_q          <= '0;
            fpb_q          <= '0;
            total_q        <= '0;
            pkts_q         <= '0;
            burst_cnt_q    <= '0;
            gap_cnt_q      <= '0;
            byte_cnt_q     <= '0;
            txd_q          <= '0;
            tx_en_q        <= 1'b0;
        end else begin
            run_q   <= run;
            start_q <= run & ~run_q;
            txd_q   <= 8'd0;
            tx_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_q && size_clip != 17'd0) begin
                        size_q         <= size_clip;
                        ifg_q          <= interframe_gap_reg;
                        ibg_q          <= interburst_gap_reg;
                        fpb_q          <= frames_per_burst_reg;
                        total_q        <= total_frames_reg;
                        pkts_q         <= '0;
                        burst_cnt_q    <= '0;
                        stop_pending_q <= 1'b0;
                        state_q        <= PREFETCH;
                    end
                end
                PREFETCH: begin
                    byte_cnt_q <= '0;
                    state_q    <= run ? FRAME : IDLE;
                end
                FRAME: begin
                    tx_en_q <= 1'b1;
                    txd_q   <= lane_byte;
                    if (!run) begin
                        stop_pending_q <= 1'b1;
                    end
                    if (frame_last) begin
                        pkts_q      <= pkts_q + 64'd1;
                        burst_cnt_q <= burst_end ? 32'd0 : burst_next;
                        gap_cnt_q   <= gap_load;
                        state_q     <= GAP;
                    end else begin
                        byte_cnt_q <= byte_cnt_q + 17'd1;
                    end
                end
                GAP: begin
                    // A stop raised during the frame lets this gap run out;
                    // a stop raised during the gap aborts it at once.
                    if (!run && !stop_pending_q) begin
                        state_q <= IDLE;
                    end else if (gap_cnt_q != 32'd0) begin
                        gap_cnt_q <= gap_cnt_q - 32'd1;
                    end else if (stop_pending_q || !run) begin
                        state_q <= IDLE;
                    end else if (total_hit) begin
                        state_q <= DONE;
                    end else begin
                        byte_cnt_q <= '0;
                        state_q    <= FRAME;
                    end
                end
                DONE: begin
                    if (!run) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gmii_txd   = txd_q;
    assign gmii_tx_en = tx_en_q;
    assign gmii_tx_er = 1'b0;
    assign pkts_reg   = pkts_q;
    assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_traffic_generator_gmii_engine.sv
// Directed bench for traffic_generator_gmii_engine: frame content, gaps, bursts,
// totals, stop, zero size, latency and reset behaviour.
module tb_traffic_generator_gmii_engine;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] control_reg = '0;
    logic [31:0] interframe_gap_reg = '0;
    logic [31:0] interburst_gap_reg = '0;
    logic [31:0] frames_per_burst_reg = '0;
    logic [63:0] total_frames_reg = '0;
    logic [15:0] frame_size_reg = '0;
    logic [31:0] frame_buf_data = '0;
    logic [8:0]  frame_buf_address = '0;
    logic        frame_buf_wr = 1'b0;
    logic [7:0]  gmii_txd;
    logic        gmii_tx_en;
    logic        gmii_tx_er;
    logic [63:0] pkts_reg;
    logic        busy;

    traffic_generator_gmii_engine #(.C_FRAME_BUF_ADDRESS_WIDTH(9)) dut (
        .clk(clk), .resetn(resetn), .control_reg(control_reg),
        .interframe_gap_reg(interframe_gap_reg), .interburst_gap_reg(interburst_gap_reg),
        .frames_per_burst_reg(frames_per_burst_reg), .total_frames_reg(total_frames_reg),
        .frame_size_reg(frame_size_reg), .frame_buf_data(frame_buf_data),
        .frame_buf_address(frame_buf_address), .frame_buf_wr(frame_buf_wr),
        .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er),
        .pkts_reg(pkts_reg), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic       en_log   [0:399];
    logic [7:0] txd_log  [0:399];
    logic       busy_log [0:399];
    int nlog, nframes, first_on, data_err, idle_err, er_err;
    int flen [0:15];
    int glen [0:15];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
        $display("check %-22s observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_word(input logic [8:0] addr, input logic [31:0] data);
        frame_buf_address = addr;
        frame_buf_data    = data;
        frame_buf_wr      = 1'b1;
        tick(1);
        frame_buf_wr      = 1'b0;
    endtask

    // Records one sample per clock; optionally drops run after sample stop_at.
    task automatic observe(input int ncyc, input int stop_at);
        er_err = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #1;
            en_log[i]   = gmii_tx_en;
            txd_log[i]  = gmii_txd;
            busy_log[i] = busy;
            if (gmii_tx_er !== 1'b0) er_err++;
            if (i == stop_at) control_reg = 32'd0;
        end
        nlog = ncyc;
    endtask

    // Splits the log into frames; template byte at frame offset n is n.
    task automatic analyze();
        int pos, idle;
        logic prev;
        nframes = 0; first_on = -1; data_err = 0; idle_err = 0;
        pos = 0; idle = 0; prev = 1'b0;
        for (int i = 0; i < 16; i++) begin
            flen[i] = 0;
            glen[i] = 0;
        end
        for (int i = 0; i < nlog; i++) begin
            if (en_log[i]) begin
                if (!prev) begin
                    if (first_on < 0) first_on = i;
                    if (nframes > 0 && nframes <= 16) glen[nframes-1] = idle;
                    nframes++;
                    pos = 0;
                end
                if (txd_log[i] !== 8'(pos)) data_err++;
                if (nframes <= 16) flen[nframes-1] = pos + 1;
                pos++;
                idle = 0;
            end else begin
                if (txd_log[i] !== 8'd0) idle_err++;
                idle++;
            end
            prev = en_log[i];
        end
    endtask

    task automatic set_cfg(input int size, input int ifg, input int ibg, input int fpb, input int total);
        frame_size_reg       = 16'(size);
        interframe_gap_reg   = 32'(ifg);
        interburst_gap_reg   = 32'(ibg);
        frames_per_burst_reg = 32'(fpb);
        total_frames_reg     = 64'(total);
    endtask

    initial begin
        // Reset state
        tick(3);
        check("rst_tx_en", 64'(gmii_tx_en), 64'd0);
        check("rst_txd", 64'(gmii_txd), 64'd0);
        check("rst_tx_er", 64'(gmii_tx_er), 64'd0);
        check("rst_pkts", pkts_reg, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        resetn = 1'b1;
        tick(2);

        for (int w = 0; w < 16; w++) begin
            write_word(9'(w), {8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)});
        end

        // 1: three 64-byte frames, ifg 12
        set_cfg(64, 12, 0, 0, 3);
        control_reg = 32'd1;
        observe(260, -1);
        analyze();
        check("t1_nframes", 64'(nframes), 64'd3);
        check("t1_len0", 64'(flen[0]), 64'd64);
        check("t1_len2", 64'(flen[2]), 64'd64);
        check("t1_gap0", 64'(glen[0]), 64'd12);
        check("t1_gap1", 64'(glen[1]), 64'd12);
        check("t1_data_err", 64'(data_err), 64'd0);
        check("t1_idle_txd_err", 64'(idle_err), 64'd0);
        check("t1_tx_er_err", 64'(er_err), 64'd0);
        check("t1_pkts", pkts_reg, 64'd3);
        check("t1_busy_done", 64'(busy), 64'd1);
        control_reg = 32'd0;
        tick(2);
        check("t1_busy_cleared", 64'(busy), 64'd0);

        // 2: bursts of 2, ifg 4 / ibg 20, total 6
        set_cfg(10, 4, 20, 2, 6);
        control_reg = 32'd1;
        observe(160, -1);
        analyze();
        check("t2_nframes", 64'(nframes), 64'd6);
        check("t2_gap0", 64'(glen[0]), 64'd4);
        check("t2_gap1", 64'(glen[1]), 64'd20);
        check("t2_gap2", 64'(glen[2]), 64'd4);
        check("t2_gap3", 64'(glen[3]), 64'd20);
        check("t2_gap4", 64'(glen[4]), 64'd4);
        check("t2_len5", 64'(flen[5]), 64'd10);
        check("t2_data_err", 64'(data_err), 64'd0);
        check("t2_pkts", pkts_reg, 64'd6);
        control_reg = 32'd0;
        tick(3);

        // 3: zero size start is ignored
        set_cfg(0, 4, 0, 0, 2);
        control_reg = 32'd1;
        observe(20, -1);
        analyze();
        check("t3_nframes", 64'(nframes), 64'd0);
        check("t3_busy", 64'(busy), 64'd0);
        check("t3_pkts_kept", pkts_reg, 64'd6);
        control_reg = 32'd0;
        tick(3);

        // 5: ifg 0 forces one idle clock; start latency is 3 clocks
        set_cfg(8, 0, 0, 0, 2);
        control_reg = 32'd1;
        observe(40, -1);
        analyze();
        check("t5_first_on", 64'(first_on), 64'd3);
        check("t5_nframes", 64'(nframes), 64'd2);
        check("t5_gap0", 64'(glen[0]), 64'd1);
        check("t5_len1", 64'(flen[1]), 64'd8);
        check("t5_data_err", 64'(data_err), 64'd0);
        control_reg = 32'd0;
        tick(3);

        // 4: unlimited run stopped mid-frame
        set_cfg(60, 12, 0, 0, 0);
        control_reg = 32'd1;
        observe(100, 30);
        analyze();
        check("t4_nframes", 64'(nframes), 64'd1);
        check("t4_len0", 64'(flen[0]), 64'd60);
        check("t4_data_err", 64'(data_err), 64'd0);
        check("t4_busy_in_gap", 64'(busy_log[73]), 64'd1);
        check("t4_idle_after_gap", 64'(busy_log[74]), 64'd0);
        check("t4_pkts", pkts_reg, 64'd1);
        tick(3);

        // 6: reset mid-frame, then identical replay from retained RAM
        set_cfg(64, 12, 0, 0, 1);
        control_reg = 32'd1;
        tick(10);
        check("t6_mid_frame_en", 64'(gmii_tx_en), 64'd1);
        resetn = 1'b0;
        tick(1);
        check("t6_rst_tx_en", 64'(gmii_tx_en), 64'd0);
        check("t6_rst_txd", 64'(gmii_txd), 64'd0);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_pkts", pkts_reg, 64'd0);
        control_reg = 32'd0;
        tick(2);
        resetn = 1'b1;
        tick(2);
        control_reg = 32'd1;
        observe(100, -1);
        analyze();
        check("t6_nframes", 64'(nframes), 64'd1);
        check("t6_len0", 64'(flen[0]), 64'd64);
        check("t6_data_err", 64'(data_err), 64'd0);
        check("t6_pkts", pkts_reg, 64'd1);
        control_reg = 32'd0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
